// File: rtl/coprocessor_timer_pkg.sv
// rtl/coprocessor_timer_pkg.sv - shared register offsets, CTRL bit positions, mode codes and FSM states
package coprocessor_timer_pkg;

  // Word offsets on the bus
  localparam logic [1:0] TIMER_CTRL   = 2'd0;
  localparam logic [1:0] TIMER_PRESET = 2'd1;
  localparam logic [1:0] TIMER_COUNT  = 2'd2;

  // CTRL field positions
  localparam int CTRL_EN_BIT   = 0;
  localparam int CTRL_MODE_LSB = 1;
  localparam int CTRL_MODE_MSB = 2;
  localparam int CTRL_IM_BIT   = 3;
  localparam int CTRL_BITS     = 4;

  // MODE codes; codes 2 and 3 fall back to one-shot
  localparam logic [1:0] TIMER_MODE_ONESHOT  = 2'd0;
  localparam logic [1:0] TIMER_MODE_PERIODIC = 2'd1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_IRQ  = 2'd3
  } timer_state_e;

endpackage

// File: rtl/coprocessor_timer_if.sv
// rtl/coprocessor_timer_if.sv - word-addressed register bus and irq line between CPU bridge and timer
interface coprocessor_timer_if #(
  parameter int WIDTH = 32
);
  logic [1:0]       addr;
  logic             writeEnable;
  logic [WIDTH-1:0] writeData;
  logic [WIDTH-1:0] readData;
  logic             irq;

  modport master (
    output addr, writeEnable, writeData,
    input  readData, irq
  );

  modport slave (
    input  addr, writeEnable, writeData,
    output readData, irq
  );
endinterface

// File: rtl/coprocessor_timer_prescaler.sv
// rtl/coprocessor_timer_prescaler.sv - tick divider, present only when TIMER_PRESCALE_EN is defined
`ifdef TIMER_PRESCALE_EN
module timer_prescaler #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic run,
  output logic tick
);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;

  // Free-running divider while run is high; restarts on clear so every period begins aligned
  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      r_cnt <= '0;
    end else if (run) begin
      r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
    end
  end

  assign tick = run && (r_cnt == LAST);
endmodule
`endif

// File: rtl/coprocessor_timer.sv
// rtl/coprocessor_timer.sv - memory-mapped countdown timer driving a CP0 interrupt line; optional prescaler under TIMER_PRESCALE_EN
module coprocessor_timer
  import coprocessor_timer_pkg::*;
#(
  parameter int WIDTH        = 32,
  parameter int PRESCALE_DIV = 4
) (
  input  logic              clk,
  input  logic              reset,
  coprocessor_timer_if.slave bus
);

  logic [CTRL_BITS-1:0] r_ctrl;
  logic [WIDTH-1:0]     r_preset;
  logic [WIDTH-1:0]     r_count;
  logic                 r_pending;
  timer_state_e         r_state;

  timer_state_e         w_state_nxt;
  logic [WIDTH-1:0]     w_count_nxt;
  logic                 w_fsm_clr_en;
  logic                 w_fsm_set_pend;
  logic                 w_tick;
  logic                 w_wr_ctrl;
  logic                 w_wr_preset;
  logic                 w_en;
  logic [1:0]           w_mode;
  logic                 w_unused;

  assign w_en        = r_ctrl[CTRL_EN_BIT];
  assign w_mode      = r_ctrl[CTRL_MODE_MSB:CTRL_MODE_LSB];
  assign w_wr_ctrl   = bus.writeEnable && (bus.addr == TIMER_CTRL);
  assign w_wr_preset = bus.writeEnable && (bus.addr == TIMER_PRESET);
  assign w_unused    = &{1'b0, bus.writeData[WIDTH-1:CTRL_BITS]};

`ifdef TIMER_PRESCALE_EN
  timer_prescaler #(
    .DIV(PRESCALE_DIV)
  ) u_prescaler (
    .clk  (clk),
    .reset(reset),
    .clear(r_state == ST_LOAD),
    .run  ((r_state == ST_CNT) && w_en),
    .tick (w_tick)
  );
`else
  localparam int LP_DIV_UNUSED = PRESCALE_DIV;
  assign w_tick = 1'b1;
`endif

  // Next-state, next-count and the one-shot side effects on EN/pending
  always_comb begin
    w_state_nxt    = r_state;
    w_count_nxt    = r_count;
    w_fsm_clr_en   = 1'b0;
    w_fsm_set_pend = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_en) w_state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        w_count_nxt = r_preset;
        w_state_nxt = ST_CNT;
      end
      ST_CNT: begin
        // Zero is tested before decrementing, so COUNT never wraps
        if (!w_en) begin
          w_state_nxt = ST_IDLE;
        end else if (w_tick) begin
          if (r_count == '0) w_state_nxt = ST_IRQ;
          else               w_count_nxt = r_count - WIDTH'(1);
        end
      end
      ST_IRQ: begin
        if (w_mode == TIMER_MODE_PERIODIC) begin
          w_state_nxt = ST_LOAD;
        end else begin
          w_fsm_clr_en   = 1'b1;
          w_fsm_set_pend = 1'b1;
          w_state_nxt    = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State and COUNT registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
    end
  end

  // CTRL: a bus write overrides the one-shot EN clear in the same cycle
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_ctrl <= '0;
    end else if (w_wr_ctrl) begin
      r_ctrl <= bus.writeData[CTRL_BITS-1:0];
    end else if (w_fsm_clr_en) begin
      r_ctrl[CTRL_EN_BIT] <= 1'b0;
    end
  end

  // PRESET is only sampled in LOAD, so writes mid-count affect the next period
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_preset <= '0;
    end else if (w_wr_preset) begin
      r_preset <= bus.writeData;
    end
  end

  // pending: any CTRL/PRESET write acknowledges, and wins over a simultaneous set
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_pending <= 1'b0;
    end else if (w_wr_ctrl || w_wr_preset) begin
      r_pending <= 1'b0;
    end else if (w_fsm_set_pend) begin
      r_pending <= 1'b1;
    end
  end

  assign bus.irq = r_ctrl[CTRL_IM_BIT] && ((r_state == ST_IRQ) || r_pending);

  // Zero-latency register read mux
  always_comb begin
    bus.readData = '0;
    case (bus.addr)
      TIMER_CTRL:   bus.readData = {{(WIDTH-CTRL_BITS){1'b0}}, r_ctrl};
      TIMER_PRESET: bus.readData = r_preset;
      TIMER_COUNT:  bus.readData = r_count;
      default:      bus.readData = '0;
    endcase
  end

endmodule

// File: tb/tb_coprocessor_timer.sv
// tb/tb_coprocessor_timer.sv - self-checking bench for coprocessor_timer
module tb_coprocessor_timer;

  logic clk;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [31:0] sb_q[$];

  coprocessor_timer_if #(.WIDTH(32)) bus ();

  coprocessor_timer #(
    .WIDTH(32),
    .PRESCALE_DIV(4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        we;
    logic [1:0]  waddr;
    logic [31:0] wdata;
    logic [1:0]  raddr;
    logic [31:0] rdata;
    logic        irq;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  task automatic check_sb(input string name, input logic [31:0] got);
    logic [31:0] exp;
    if (sb_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: got 0x%08h expected <scoreboard empty>", name, got);
    end else begin
      exp = sb_q.pop_front();
      check(name, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    bus.addr        = a;
    bus.writeData   = d;
    bus.writeEnable = 1'b1;
    @(posedge clk);
    #1;
    bus.writeEnable = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] v);
    bus.addr = a;
    #1;
    v = bus.readData;
  endtask

  task automatic wait_irq(input int max, output int k);
    k = 0;
    for (int i = 1; i <= max; i++) begin
      @(posedge clk);
      #1;
      if (bus.irq) begin
        k = i;
        break;
      end
    end
  endtask

  task automatic wait_count(input logic [31:0] val, input int max, output logic ok);
    ok = 1'b0;
    bus.addr = 2'd2;
    for (int i = 0; i < max; i++) begin
      @(posedge clk);
      #1;
      if (bus.readData == val) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v;
    int          k;
    logic        ok;
    logic        seen;

    reset           = 1'b0;
    bus.addr        = 2'd0;
    bus.writeEnable = 1'b0;
    bus.writeData   = 32'd0;
    step(2);
    reset = 1'b1;

    for (int a = 0; a < 4; a++) begin
      rd(a[1:0], v);
      check("reset_read", v, 32'd0);
    end
    check("reset_irq", {31'd0, bus.irq}, 32'd0);

    // Register access vectors, all with EN=0 so nothing counts
    vecs[0] = '{1'b1, 2'd1, 32'h1234_5678, 2'd1, 32'h1234_5678, 1'b0};
    vecs[1] = '{1'b1, 2'd0, 32'hFFFF_FFF6, 2'd0, 32'h0000_0006, 1'b0};
    vecs[2] = '{1'b1, 2'd2, 32'h0000_AAAA, 2'd2, 32'h0000_0000, 1'b0};
    vecs[3] = '{1'b1, 2'd3, 32'h0000_5555, 2'd3, 32'h0000_0000, 1'b0};
    vecs[4] = '{1'b0, 2'd0, 32'h0000_0000, 2'd1, 32'h1234_5678, 1'b0};
    vecs[5] = '{1'b1, 2'd0, 32'h0000_0000, 2'd0, 32'h0000_0000, 1'b0};
    vecs[6] = '{1'b1, 2'd1, 32'h0000_0000, 2'd1, 32'h0000_0000, 1'b0};
    for (int i = 0; i < 7; i++) begin
      if (vecs[i].we) bus_write(vecs[i].waddr, vecs[i].wdata);
      else            step(1);
      sb_q.push_back(vecs[i].rdata);
      rd(vecs[i].raddr, v);
      check_sb($sformatf("vec%0d_rdata", i), v);
      check($sformatf("vec%0d_irq", i), {31'd0, bus.irq}, {31'd0, vecs[i].irq});
    end

    // Reset mid-count
    bus_write(2'd1, 32'd100);
    bus_write(2'd0, 32'h9);
    step(10);
    rd(2'd2, v);
    check("t1_count_before_reset", v, 32'd92);
    reset = 1'b0;
    step(2);
    reset = 1'b1;
    for (int a = 0; a < 4; a++) begin
      rd(a[1:0], v);
      check("t1_read_after_reset", v, 32'd0);
    end
    check("t1_irq_after_reset", {31'd0, bus.irq}, 32'd0);
    step(5);
    rd(2'd2, v);
    check("t1_count_stays_zero", v, 32'd0);

    // One-shot, PRESET=5: irq after E8, held by pending, cleared by CTRL write
    bus_write(2'd1, 32'd5);
    sb_q.push_back(32'd8);
    bus_write(2'd0, 32'h9);
    wait_irq(20, k);
    check_sb("t2_irq_latency", k);
    step(3);
    check("t2_irq_held", {31'd0, bus.irq}, 32'd1);
    rd(2'd0, v);
    check("t2_ctrl_en_cleared", v, 32'h8);
    bus_write(2'd0, 32'h8);
    check("t2_irq_dropped", {31'd0, bus.irq}, 32'd0);

    // Periodic, PRESET=3: 1-cycle pulse every 6 cycles
    bus_write(2'd1, 32'd3);
    sb_q.push_back(32'd6);
    bus_write(2'd0, 32'hB);
    wait_irq(20, k);
    check_sb("t3_first_irq", k);
    step(2);
    rd(2'd2, v);
    check("t3_count_3", v, 32'd3);
    step(1);
    rd(2'd2, v);
    check("t3_count_2", v, 32'd2);
    step(1);
    rd(2'd2, v);
    check("t3_count_1", v, 32'd1);
    step(1);
    rd(2'd2, v);
    check("t3_count_0", v, 32'd0);
    sb_q.push_back(32'd1);
    wait_irq(20, k);
    check_sb("t3_period0_end", k);
    for (int p = 1; p < 4; p++) begin
      sb_q.push_back(32'd6);
      wait_irq(20, k);
      check_sb($sformatf("t3_period%0d", p), k);
    end
    bus_write(2'd0, 32'h0);

    // Masked one-shot: irq never rises, EN auto-clears, CTRL write leaves irq low
    bus_write(2'd1, 32'd5);
    bus_write(2'd0, 32'h1);
    seen = 1'b0;
    repeat (12) begin
      step(1);
      if (bus.irq) seen = 1'b1;
    end
    check("t4_irq_masked", {31'd0, seen}, 32'd0);
    rd(2'd0, v);
    check("t4_en_cleared", v, 32'h0);
    bus_write(2'd0, 32'h8);
    step(2);
    check("t4_irq_after_unmask", {31'd0, bus.irq}, 32'd0);

    // Disable mid-count, COUNT holds, re-enable reloads
    bus_write(2'd1, 32'd20);
    bus_write(2'd0, 32'h9);
    wait_count(32'd8, 40, ok);
    check("t5_reach_8", {31'd0, ok}, 32'd1);
    bus_write(2'd0, 32'h8);
    step(2);
    rd(2'd2, v);
    check("t5_count_holds", v, 32'd7);
    rd(2'd0, v);
    check("t5_ctrl", v, 32'h8);
    check("t5_irq", {31'd0, bus.irq}, 32'd0);
    bus_write(2'd0, 32'h9);
    step(2);
    rd(2'd2, v);
    check("t5_reload", v, 32'd20);
    bus_write(2'd0, 32'h0);

    // PRESET change mid-count in periodic mode; COUNT write ignored
    bus_write(2'd1, 32'd10);
    bus_write(2'd0, 32'hB);
    wait_count(32'd6, 40, ok);
    check("t6_reach_6", {31'd0, ok}, 32'd1);
    bus_write(2'd1, 32'd2);
    bus_write(2'd2, 32'h55);
    rd(2'd2, v);
    check("t6_count_write_ignored", v, 32'd4);
    sb_q.push_back(32'd5);
    wait_irq(20, k);
    check_sb("t6_old_period_end", k);
    sb_q.push_back(32'd5);
    wait_irq(20, k);
    check_sb("t6_new_period", k);
    bus_write(2'd0, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/coprocessor_timer.md
Name: coprocessor_timer

Overview:
- Memory-mapped countdown timer that raises an interrupt request line toward CP0.
- Its `irq` output drives one bit of CP0's `externalInterrupt[15:10]`; the CPU reaches it through the bridge's word-addressed store/load path.
- Supports one-shot mode and auto-reload periodic mode.
- Acts as the interrupt source end of the CP0 interrupt interface.

Parameters:
- WIDTH, 32, width of the PRESET and COUNT registers and of the data bus.
- PRESCALE_DIV, 4, tick divider; used only when TIMER_PRESCALE_EN is defined; legal range is 2 or more.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-low reset; sampled on the rising edge of clk; low means reset.
- addr  input  2  word select: 0 = CTRL, 1 = PRESET, 2 = COUNT, 3 = reserved.
- writeEnable  input  1  bus write strobe, qualified by addr.
- writeData  input  WIDTH  bus write data.
- readData  output  WIDTH  combinational read of the register selected by addr.
- irq  output  1  interrupt request to CP0, active high.

Behaviour:
- Registers:
  - CTRL[3:0]: bit0 EN, bits2:1 MODE, bit3 IM.
  - CTRL[WIDTH-1:4] are not stored and read as 0.
  - MODE 0 = one-shot, MODE 1 = periodic. MODE 2 and 3 are reserved and behave as MODE 0.
  - PRESET is read/write. COUNT is read-only; writes to addr 2 and addr 3 are ignored.
- Reset (reset low at a rising edge):
  - CTRL=0, PRESET=0, COUNT=0, state=IDLE, pending=0.
  - Hence irq=0 and readData=0 for every addr.
  - Reset mid-count aborts the count immediately, with no irq.
- readData:
  - addr 0 returns zero-extended CTRL; addr 1 returns PRESET; addr 2 returns COUNT; addr 3 returns 0.
  - No read latency.
- irq = IM & ((state==IRQ) | pending). It is combinational from registered state only.
- FSM, 2-bit encoding IDLE=0, LOAD=1, CNT=2, IRQ=3:
  - IDLE: if EN then LOAD; otherwise stay, and COUNT holds.
  - LOAD: COUNT <= PRESET, then CNT.
  - CNT: if !EN then IDLE, and COUNT holds its value. Else if COUNT==0 then IRQ. Else COUNT <= COUNT-1.
  - IRQ, MODE 0: EN <= 0, pending <= 1, then IDLE. irq stays high until pending is cleared.
  - IRQ, MODE 1: go to LOAD with pending unchanged. irq is a one-cycle pulse.
- Latency:
  - CTRL write enabling the timer at edge E0 gives LOAD at E1, COUNT=PRESET at E2, and COUNT=0 at E(2+N).
  - irq rises after edge E(3+N), where N=PRESET.
  - PRESET=0 therefore gives irq after E3.
  - MODE 1 period is N+3 cycles, measured from irq rise to irq rise.
- pending is cleared by any write to CTRL or PRESET.
- Clearing IM masks irq without clearing pending.
- Simultaneous events:
  - A bus write to CTRL in the same cycle as the IRQ-state EN clear: the bus write wins for all CTRL bits, and the pending clear wins over the pending set.
  - A PRESET write while counting does not affect COUNT; it takes effect at the next LOAD.
  - Setting EN while in IRQ state with MODE 0 is overridden by the bus write, so EN stays 1; the next state is IDLE and then LOAD follows.
- Arithmetic: COUNT decrement is unsigned. COUNT never wraps, because 0 is detected before any decrement.

Optional Feature:
- Macro name: TIMER_PRESCALE_EN.
- When defined:
  - A prescaler counter of width clog2(PRESCALE_DIV) is added.
  - It is cleared in LOAD and in reset.
  - It wraps every PRESCALE_DIV cycles while in CNT with EN set.
  - The CNT decrement and the COUNT==0 check happen only on the wrap cycle.
  - Latency becomes irq after E(2+(N+1)*PRESCALE_DIV).
- When undefined: a tick occurs every cycle and behaviour is exactly as specified above.

Decomposition:
- Shared package/header (constants include file):
  - Register offsets TIMER_CTRL=0, TIMER_PRESET=1, TIMER_COUNT=2.
  - CTRL bit positions for EN, MODE and IM.
  - Mode codes TIMER_MODE_ONESHOT=0, TIMER_MODE_PERIODIC=1.
  - State encodings for IDLE, LOAD, CNT and IRQ.
- Sub-module: timer_prescaler, a tick generator with inputs clk, reset, clear and run and output tick. It is instantiated only under TIMER_PRESCALE_EN. Everything else stays in one module.

Test Plan:
1. Reset low for 2 cycles mid-count (PRESET=100, EN=1) -> COUNT=0, CTRL=0, irq=0, readData=0 for all addr.
2. PRESET=5, CTRL=0x9 (EN, MODE 0, IM) at E0 -> irq rises after E8 and stays high; CTRL reads 0x8. A write of CTRL=0x8 drops irq on the next cycle.
3. PRESET=3, CTRL=0xB (MODE 1) -> irq is a 1-cycle pulse every 6 cycles for at least 4 periods; COUNT sequence is 3,2,1,0.
4. MODE 0 PRESET=5 with CTRL=0x1 (IM=0) -> irq never rises, pending is set. A later write of CTRL=0x8 clears pending, so irq stays 0.
5. Mid-count at COUNT=7, write CTRL=0x8 (EN=0) -> state IDLE, COUNT holds 7. Re-enabling reloads PRESET and does not resume from 7.
6. PRESET=10 counting, write PRESET=2 at COUNT=6 -> the current period still ends from 6. In MODE 1 the next period uses 2, giving a period of 5. A write to addr 2 is ignored.
